rcc_apb_gen2: RTL and testbench
===============================

Name: rcc_apb_gen2

Overview:
Parametrised reset-and-clock controller for the SoC peripheral bus. It is the successor to the fixed six-peripheral RCC. For NCH peripheral channels it provides:
- a software-writable clock-enable register;
- a per-channel programmable prescaler that produces clock-enable strobes (no gated clocks);
- a per-channel stretched synchronous reset, triggered by software or by global reset.

It sits on the APB-style peripheral bus next to the PLL wrappers. It drives the clock-enable and reset inputs of GPIO, USART, SPI, I2C, TIM, WDG and future channels.

Parameters:
NCH, 8, number of peripheral channels (1..16)
DIV_W, 8, prescaler divisor width in bits (1..16)
RST_CYCLES, 16, length of stretched channel reset in clocks (2..255)
ENR_RST, 32'hFFFFFFFF, reset value of the enable register (bits >= NCH ignored)

Ports:
io_ahb_PCLK  in  1  single clock for all logic
io_ahb_PRESET  in  1  synchronous, active-high reset
io_ahb_PADDR  in  5  word address
io_ahb_PSEL  in  1  slave select
io_ahb_PENABLE  in  1  access phase
io_ahb_PWRITE  in  1  1 = write
io_ahb_PWDATA  in  32  write data
io_ahb_PREADY  out  1  constant 1
io_ahb_PRDATA  out  32  read data
io_ahb_PSLVERROR  out  1  access to an unmapped address
ch_clk_en  out  NCH  per-channel clock-enable strobe
ch_rst  out  NCH  per-channel synchronous reset, active high
ch_rst_busy  out  NCH  mirror of ch_rst, for interrupt/status use

Behaviour:
- Reset is synchronous and active-high: one clock, io_ahb_PCLK; reset io_ahb_PRESET is synchronous, active-high. All state updates on the rising edge.
- Values while io_ahb_PRESET = 1:
  - ENR = ENR_RST[NCH-1:0];
  - all DIV registers = 0;
  - all prescaler counters = 0;
  - all reset counters = RST_CYCLES;
  - ch_rst = all 1;
  - ch_clk_en = 0;
  - PRDATA = 0;
  - PSLVERROR = 0.
- Register map (word addresses):
  - 0x00 ENR, read/write, bits [NCH-1:0].
  - 0x01 RSTR, write-1-to-trigger; read returns the ch_rst_busy bits.
  - 0x02 ID, read-only: {8'h02, 8'(NCH), 8'(DIV_W), 8'(RST_CYCLES)}.
  - 0x10+i DIVi, read/write, bits [DIV_W-1:0], for i < NCH.
  - Unused register bits read as 0.
- Bus handling:
  - Writes take effect when PSEL & PENABLE & PWRITE, at the end of that cycle.
  - Reads are combinational during PSEL & PENABLE & ~PWRITE; PRDATA = 0 otherwise.
  - PREADY = 1 always, so there are no wait states.
  - PSLVERROR = PSEL & PENABLE & (address unmapped, or DIVi with i >= NCH).
  - Erroneous writes have no effect.
- Prescaler, channel i:
  - Counter cnt_i has width DIV_W.
  - If ENR[i] = 0: cnt_i <= 0 and ch_clk_en[i] = 0.
  - Else if cnt_i == DIVi: ch_clk_en[i] = 1 and cnt_i <= 0.
  - Else: ch_clk_en[i] = 0 and cnt_i <= cnt_i + 1.
  - So DIVi = 0 gives a strobe every cycle; DIVi = N gives a strobe every N+1 cycles.
  - ch_clk_en is combinational from the registered cnt/ENR/DIV.
  - A write to DIVi clears cnt_i in the same edge. The next strobe follows the new divisor, counted from 0.
  - A write setting ENR[i] 0->1: the first strobe comes DIVi+1 cycles after the write edge, or in the next cycle if DIVi = 0.
- Reset stretcher, channel i:
  - Counter rc_i has 8 bits; ch_rst[i] = (rc_i != 0).
  - A write of 1 to RSTR bit i loads rc_i = RST_CYCLES.
  - Otherwise rc_i decrements while non-zero.
  - After global reset release, every ch_rst stays high for exactly RST_CYCLES further cycles.
  - Re-triggering while busy reloads RST_CYCLES, extending the pulse; it is not additive.
  - Writing 0 to a bit has no effect. Bits >= NCH are ignored.
  - ch_rst is independent of ENR, so a disabled channel can still be reset.
- Simultaneous events:
  - A global reset overrides any bus write in the same cycle.
  - An RSTR write in the same cycle as the counter reaching 0 reloads the counter, so ch_rst never drops.
  - An ENR write and a DIV write to the same channel cannot occur in one cycle (single bus).

Test Plan:
- Reset release with RST_CYCLES=16: ch_rst = all 1 for 16 cycles after PRESET falls, then 0. ENR reads 0xFF and ID reads 0x02080810.
- Write DIV2 = 3 with ENR[2] = 1: ch_clk_en[2] pulses 1 cycle in every 4, first pulse 4 cycles after the write. DIV2 = 0 then gives a constant 1.
- Write ENR = 0xFB: ch_clk_en[2] = 0 from the next cycle and stays 0. Rewriting 0xFF restarts strobes with the counter from 0.
- Write RSTR = 0x05: ch_rst[0] and ch_rst[2] are high for 16 cycles and other channels stay 0. Re-write 0x01 at cycle 10: ch_rst[0] stays high until cycle 26 and never drops in between.
- Read 0x03 and write 0x18 (NCH=8): PSLVERROR = 1 in the access phase, PRDATA = 0, no register changes. Valid accesses keep PSLVERROR = 0 and PREADY = 1 throughout.
- PRESET asserted mid-pulse and mid-prescale: the next edge restores all reset values. DIV registers read 0 and ch_clk_en = 0 while in reset.

Source files
------------

// File: rtl/rcc_apb_gen2_if.sv
// Peripheral-bus bundle for the reset-and-clock controller.
// The master drives address, select and write data; the slave returns ready, read data and error.
interface rcc_apb_gen2_if;
  logic [4:0]  io_ahb_PADDR;
  logic        io_ahb_PSEL;
  logic        io_ahb_PENABLE;
  logic        io_ahb_PWRITE;
  logic [31:0] io_ahb_PWDATA;
  logic        io_ahb_PREADY;
  logic [31:0] io_ahb_PRDATA;
  logic        io_ahb_PSLVERROR;

  modport master (
    output io_ahb_PADDR, io_ahb_PSEL, io_ahb_PENABLE, io_ahb_PWRITE, io_ahb_PWDATA,
    input  io_ahb_PREADY, io_ahb_PRDATA, io_ahb_PSLVERROR
  );

  modport slave (
    input  io_ahb_PADDR, io_ahb_PSEL, io_ahb_PENABLE, io_ahb_PWRITE, io_ahb_PWDATA,
    output io_ahb_PREADY, io_ahb_PRDATA, io_ahb_PSLVERROR
  );
endinterface

// File: rtl/rcc_apb_gen2.sv
// Parametrised reset-and-clock controller: per-channel enable register, prescaled
// clock-enable strobes and stretched synchronous channel resets behind a zero-wait bus slave.
module rcc_apb_gen2 #(
  parameter int unsigned NCH        = 8,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RST_CYCLES = 16,
  parameter logic [31:0] ENR_RST    = 32'hFFFF_FFFF
) (
  input  logic           io_ahb_PCLK,
  input  logic           io_ahb_PRESET,
  rcc_apb_gen2_if.slave  apb,
  output logic [NCH-1:0] ch_clk_en,
  output logic [NCH-1:0] ch_rst,
  output logic [NCH-1:0] ch_rst_busy
);

  localparam logic [7:0]  RST_LOAD = 8'(RST_CYCLES);
  localparam logic [31:0] ID_VAL   = {8'h02, 8'(NCH), 8'(DIV_W), 8'(RST_CYCLES)};

  logic [NCH-1:0]   enr_r;
  logic [DIV_W-1:0] div_r     [NCH];
  logic [DIV_W-1:0] cnt_r     [NCH];
  logic [DIV_W-1:0] cnt_nxt_s [NCH];
  logic [7:0]       rc_r      [NCH];

  logic             access_s;
  logic             wr_s;
  logic             rd_s;
  logic             hit_enr_s;
  logic             hit_rstr_s;
  logic             hit_id_s;
  logic             hit_div_s;
  logic             mapped_s;
  logic [NCH-1:0]   div_sel_s;
  logic [DIV_W-1:0] div_rd_s;
  logic [31:0]      rdata_s;
  logic [NCH-1:0]   strobe_s;
  logic [NCH-1:0]   rc_busy_s;
  logic [NCH-1:0]   rst_trig_s;
  logic             unused_pwdata_s;

  // Address decode; DIV slots beyond NCH stay unmapped.
  always_comb begin
    access_s   = apb.io_ahb_PSEL & apb.io_ahb_PENABLE;
    wr_s       = access_s & apb.io_ahb_PWRITE;
    rd_s       = access_s & ~apb.io_ahb_PWRITE & ~io_ahb_PRESET;
    hit_enr_s  = (apb.io_ahb_PADDR == 5'h00);
    hit_rstr_s = (apb.io_ahb_PADDR == 5'h01);
    hit_id_s   = (apb.io_ahb_PADDR == 5'h02);
    div_sel_s  = '0;
    for (int i = 0; i < NCH; i++) begin
      div_sel_s[i] = (apb.io_ahb_PADDR == (5'h10 + 5'(i)));
    end
    hit_div_s  = |div_sel_s;
    mapped_s   = hit_enr_s | hit_rstr_s | hit_id_s | hit_div_s;
  end

  // Read mux; data is only driven during a read access phase.
  always_comb begin
    div_rd_s = '0;
    for (int i = 0; i < NCH; i++) begin
      div_rd_s = div_rd_s | (div_r[i] & {DIV_W{div_sel_s[i]}});
    end
    rdata_s = 32'h0000_0000;
    if (rd_s) begin
      if (hit_enr_s) begin
        rdata_s = 32'(enr_r);
      end else if (hit_rstr_s) begin
        rdata_s = 32'(rc_busy_s);
      end else if (hit_id_s) begin
        rdata_s = ID_VAL;
      end else if (hit_div_s) begin
        rdata_s = 32'(div_rd_s);
      end else begin
        rdata_s = 32'h0000_0000;
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign apb.io_ahb_PREADY    = 1'b1;
  assign apb.io_ahb_PRDATA    = rdata_s;
  assign apb.io_ahb_PSLVERROR = access_s & ~mapped_s & ~io_ahb_PRESET;

  // Prescaler: strobe when the counter meets the divisor, then restart from zero.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      strobe_s[i]  = 1'b0;
      cnt_nxt_s[i] = '0;
      if (!enr_r[i]) begin
        strobe_s[i]  = 1'b0;
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == div_r[i]) begin
        strobe_s[i]  = 1'b1;
        cnt_nxt_s[i] = '0;
      end else begin
        strobe_s[i]  = 1'b0;
        cnt_nxt_s[i] = cnt_r[i] + DIV_W'(1);
      end
    end
  end

  // Reset stretcher status and software trigger bits.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      rc_busy_s[i] = (rc_r[i] != 8'h00);
    end
    if (wr_s && hit_rstr_s) begin
      rst_trig_s = apb.io_ahb_PWDATA[NCH-1:0];
    end else begin
      rst_trig_s = '0;
    end
  end

  assign ch_clk_en       = strobe_s & {NCH{~io_ahb_PRESET}};
  assign ch_rst          = rc_busy_s;
  assign ch_rst_busy     = rc_busy_s;
  assign unused_pwdata_s = &{1'b0, apb.io_ahb_PWDATA};

  // Register state; global reset wins over any bus write in the same cycle.
  always_ff @(posedge io_ahb_PCLK) begin
    if (io_ahb_PRESET) begin
      enr_r <= ENR_RST[NCH-1:0];
      for (int i = 0; i < NCH; i++) begin
        div_r[i] <= '0;
        cnt_r[i] <= '0;
        rc_r[i]  <= RST_LOAD;
      end
    end else begin
      if (wr_s && hit_enr_s) begin
        enr_r <= apb.io_ahb_PWDATA[NCH-1:0];
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_s && div_sel_s[i]) begin
          div_r[i] <= apb.io_ahb_PWDATA[DIV_W-1:0];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_nxt_s[i];
        end
        // A trigger on the cycle the count would reach zero reloads it, so the pulse never drops.
        if (rst_trig_s[i]) begin
          rc_r[i] <= RST_LOAD;
        end else if (rc_busy_s[i]) begin
          rc_r[i] <= rc_r[i] - 8'h01;
        end
      end
    end
  end

endmodule

// File: tb/tb_rcc_apb_gen2.sv
// Directed self-checking bench for rcc_apb_gen2 (NCH=8, DIV_W=8, RST_CYCLES=16).
module tb_rcc_apb_gen2;

  logic       clk;
  logic       preset;
  logic [7:0] ch_clk_en;
  logic [7:0] ch_rst;
  logic [7:0] ch_rst_busy;
  int         checks;
  int         errors;

  rcc_apb_gen2_if bus ();

  rcc_apb_gen2 #(
    .NCH        (8),
    .DIV_W      (8),
    .RST_CYCLES (16),
    .ENR_RST    (32'hFFFF_FFFF)
  ) dut (
    .io_ahb_PCLK   (clk),
    .io_ahb_PRESET (preset),
    .apb           (bus.slave),
    .ch_clk_en     (ch_clk_en),
    .ch_rst        (ch_rst),
    .ch_rst_busy   (ch_rst_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Setup phase, access phase (sampled), then idle; returns at the negedge after the access edge.
  task automatic apb_access(input logic wr, input logic [4:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err, output logic rdy);
    @(negedge clk);
    bus.io_ahb_PSEL    = 1'b1;
    bus.io_ahb_PENABLE = 1'b0;
    bus.io_ahb_PWRITE  = wr;
    bus.io_ahb_PADDR   = a;
    bus.io_ahb_PWDATA  = d;
    @(negedge clk);
    bus.io_ahb_PENABLE = 1'b1;
    #1;
    rd  = bus.io_ahb_PRDATA;
    err = bus.io_ahb_PSLVERROR;
    rdy = bus.io_ahb_PREADY;
    @(negedge clk);
    bus.io_ahb_PSEL    = 1'b0;
    bus.io_ahb_PENABLE = 1'b0;
    bus.io_ahb_PWRITE  = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    logic        rdy;
    apb_access(1'b1, a, d, rd, err, rdy);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp,
                        input logic exp_err);
    logic [31:0] rd;
    logic        err;
    logic        rdy;
    apb_access(1'b0, a, 32'h0, rd, err, rdy);
    chk({name, "_rdata"}, rd, exp);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  // Strobe on channel ch expected at cycle k after the write edge when k is a multiple of period (0 = never).
  task automatic strobe_seq(input string name, input int ch, input int period, input int n);
    logic exp;
    for (int k = 1; k <= n; k++) begin
      #1;
      exp = (period != 0) && ((k % period) == 0);
      chk($sformatf("%s_k%0d", name, k), 32'(ch_clk_en[ch]), 32'(exp));
      @(negedge clk);
    end
  endtask

  // Trigger RSTR=m1, then re-trigger m2 with the access phase at cycle e after the first write edge.
  task automatic rst_seq(input string name, input logic [7:0] m1, input logic [7:0] m2, input int e);
    logic [7:0] exp;
    wr_reg(5'h01, {24'h0, m1});
    for (int k = 1; k <= e + 18; k++) begin
      if (k == e - 1) begin
        bus.io_ahb_PSEL    = 1'b1;
        bus.io_ahb_PWRITE  = 1'b1;
        bus.io_ahb_PADDR   = 5'h01;
        bus.io_ahb_PWDATA  = {24'h0, m2};
      end
      if (k == e) begin
        bus.io_ahb_PENABLE = 1'b1;
      end
      if (k == e + 1) begin
        bus.io_ahb_PSEL    = 1'b0;
        bus.io_ahb_PENABLE = 1'b0;
        bus.io_ahb_PWRITE  = 1'b0;
      end
      #1;
      for (int b = 0; b < 8; b++) begin
        exp[b] = m2[b] ? (k <= e + 16) : (m1[b] ? (k <= 16) : 1'b0);
      end
      chk($sformatf("%s_rst_k%0d", name, k), 32'(ch_rst), 32'(exp));
      chk($sformatf("%s_busy_k%0d", name, k), 32'(ch_rst_busy), 32'(exp));
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic        rdy;

    vecs[0]  = '{1'b0, 5'h00, 32'h0000_0000, 32'h0000_00FF, 1'b0};
    vecs[1]  = '{1'b0, 5'h02, 32'h0000_0000, 32'h0208_0810, 1'b0};
    vecs[2]  = '{1'b0, 5'h10, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 5'h10, 32'hABCD_1234, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 5'h10, 32'h0000_0000, 32'h0000_0034, 1'b0};
    vecs[5]  = '{1'b1, 5'h17, 32'h0000_01FF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 5'h17, 32'h0000_0000, 32'h0000_00FF, 1'b0};
    vecs[7]  = '{1'b0, 5'h03, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 5'h18, 32'h0000_0055, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 5'h18, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 5'h1F, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 5'h00, 32'hFFFF_FF0F, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 5'h00, 32'h0000_0000, 32'h0000_000F, 1'b0};
    vecs[13] = '{1'b1, 5'h00, 32'h0000_00FF, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b1, 5'h02, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 5'h02, 32'h0000_0000, 32'h0208_0810, 1'b0};
    vecs[16] = '{1'b0, 5'h01, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[17] = '{1'b0, 5'h10, 32'h0000_0000, 32'h0000_0034, 1'b0};
    vecs[18] = '{1'b0, 5'h0F, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[19] = '{1'b0, 5'h04, 32'h0000_0000, 32'h0000_0000, 1'b1};

    checks = 0;
    errors = 0;
    preset = 1'b1;
    bus.io_ahb_PSEL    = 1'b0;
    bus.io_ahb_PENABLE = 1'b0;
    bus.io_ahb_PWRITE  = 1'b0;
    bus.io_ahb_PADDR   = 5'h00;
    bus.io_ahb_PWDATA  = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ch_rst", 32'(ch_rst), 32'h0000_00FF);
    chk("rst_ch_busy", 32'(ch_rst_busy), 32'h0000_00FF);
    chk("rst_clk_en", 32'(ch_clk_en), 32'h0);
    chk("rst_prdata", bus.io_ahb_PRDATA, 32'h0);
    chk("rst_pslverr", 32'(bus.io_ahb_PSLVERROR), 32'h0);

    // Release: every channel reset stays high for exactly 16 cycles
    preset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("release_k%0d", k), 32'(ch_rst), (k < 16) ? 32'h0000_00FF : 32'h0);
      @(negedge clk);
      #1;
    end

    // Register-access vector table
    for (int i = 0; i < 20; i++) begin
      apb_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, rdy);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'h1);
    end

    // Prescaler on channel 2
    wr_reg(5'h12, 32'h3);
    strobe_seq("div3", 2, 4, 12);
    wr_reg(5'h12, 32'h0);
    strobe_seq("div0", 2, 1, 4);
    wr_reg(5'h00, 32'hFB);
    strobe_seq("disabled", 2, 0, 6);
    wr_reg(5'h12, 32'h2);
    strobe_seq("disabled_div2", 2, 0, 3);
    wr_reg(5'h00, 32'hFF);
    strobe_seq("reenable_div2", 2, 3, 9);

    // Reset stretcher: retrigger mid-pulse, and retrigger on the cycle the count reaches zero
    rst_seq("retrig", 8'h05, 8'h01, 9);
    rst_seq("edge", 8'h02, 8'h02, 16);

    // Global reset mid-pulse and mid-prescale
    wr_reg(5'h12, 32'h3);
    wr_reg(5'h01, 32'h08);
    repeat (2) @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_ch_rst", 32'(ch_rst), 32'h0000_00FF);
    chk("mid_rst_busy", 32'(ch_rst_busy), 32'h0000_00FF);
    chk("mid_rst_clk_en", 32'(ch_clk_en), 32'h0);
    rd_chk("mid_rst_div2", 5'h12, 32'h0, 1'b0);
    rd_chk("mid_rst_unmapped", 5'h03, 32'h0, 1'b0);
    chk("mid_rst_clk_en2", 32'(ch_clk_en), 32'h0);
    @(negedge clk);
    preset = 1'b0;
    repeat (17) @(negedge clk);
    rd_chk("post_rst_enr", 5'h00, 32'h0000_00FF, 1'b0);
    rd_chk("post_rst_div2", 5'h12, 32'h0, 1'b0);
    rd_chk("post_rst_div7", 5'h17, 32'h0, 1'b0);
    #1;
    chk("post_rst_clk_en", 32'(ch_clk_en), 32'h0000_00FF);
    chk("post_rst_ch_rst", 32'(ch_rst), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
